// File: rtl/bp_stall_prof_pkg.sv
// Shared definitions for the stall-histogram profiler: reason encoding and
// read-port address map helpers.
package bp_stall_prof_pkg;

  typedef enum logic [4:0] {
    e_stall_unknown          = 5'd0,
    e_icache_miss            = 5'd1,
    e_itlb_miss              = 5'd2,
    e_branch_mispredict      = 5'd3,
    e_fe_queue_stall         = 5'd4,
    e_fe_cmd_stall           = 5'd5,
    e_fence_stall            = 5'd6,
    e_dcache_miss            = 5'd7,
    e_dtlb_miss              = 5'd8,
    e_long_haul              = 5'd9,
    e_control_haz            = 5'd10,
    e_data_haz               = 5'd11,
    e_load_dep               = 5'd12,
    e_mul_dep                = 5'd13,
    e_fma_dep                = 5'd14,
    e_sb_iraw_dep            = 5'd15,
    e_sb_fraw_dep            = 5'd16,
    e_sb_iwaw_dep            = 5'd17,
    e_sb_fwaw_dep            = 5'd18,
    e_struct_haz             = 5'd19,
    e_exception              = 5'd20,
    e_interrupt              = 5'd21,
    e_cmd_fence              = 5'd22,
    e_mispredict_recover     = 5'd23
  } bp_stall_reason_e;

  localparam int stall_reasons_gp = 24;

  // Read map: reasons occupy 0..R-1, followed by instret and cycles.
  function automatic int instret_addr(input int num_reasons);
    return num_reasons;
  endfunction

  function automatic int cycles_addr(input int num_reasons);
    return num_reasons + 1;
  endfunction

  localparam int instret_addr_gp = stall_reasons_gp;
  localparam int cycles_addr_gp  = stall_reasons_gp + 1;

  function automatic int addr_width(input int num_reasons);
    return $clog2(num_reasons + 2);
  endfunction

endpackage

// File: rtl/bp_stall_attrib_pipe.sv
// Shadow attribution pipe: per-stage stall events are OR-accumulated down to
// the commit-aligned tail, where the highest-index reason wins.
module bp_stall_attrib_pipe
  import bp_stall_prof_pkg::*;
#(
  parameter int num_stages_p  = 8,
  parameter int num_reasons_p = 24,
  localparam int idx_width_lp = $clog2(num_reasons_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_li,
  input  logic                                   flush_i,
  input  logic [num_stages_p*num_reasons_p-1:0]  stage_event_i,
  output logic [idx_width_lp-1:0]                reason_o,
  output logic                                   reason_v_o
);

  logic [num_stages_p-1:0][num_reasons_p-1:0] stage_q, stage_d;
  logic [num_reasons_p-1:0]                   tail;
  logic                                       tail_bit0_unused;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    stage_d = '0;
    if (!flush_i) begin
      stage_d[0] = stage_event_i[0 +: num_reasons_p];
      for (int s = 1; s < num_stages_p; s++) begin
        stage_d[s] = stage_q[s-1] | stage_event_i[s*num_reasons_p +: num_reasons_p];
      end
    end
  end

  // NOTE: the pipe is a flop array, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk_i or negedge reset_li) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_li) stage_q <= '0;
    else           stage_q <= stage_d;
  end

  assign tail             = stage_q[num_stages_p-1];
  assign tail_bit0_unused = tail[0];

  // Later iterations override earlier ones, so the highest set index wins.
  always_comb begin
    reason_o   = idx_width_lp'(e_stall_unknown);
    reason_v_o = 1'b0;
    for (int r = 1; r < num_reasons_p; r++) begin
      if (tail[r]) begin
        reason_o   = idx_width_lp'(r);
        reason_v_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_nonsynth_stall_histogram.sv
// Per-core stall histogram: attributes every counted cycle to instret or one
// stall reason, with cumulative or fixed-window accumulation and a read port.
module bp_nonsynth_stall_histogram
  import bp_stall_prof_pkg::*;
#(
  parameter int  num_stages_p    = 8,
  parameter int  num_reasons_p   = 24,
  parameter int  cnt_width_p     = 32,
  parameter int  window_cycles_p = 1024,
  localparam int addr_width_lp   = addr_width(num_reasons_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_li,
  input  logic                                  freeze_i,
  input  logic                                  en_i,
  input  logic                                  clear_i,
  input  logic                                  mode_i,
  input  logic [num_stages_p*num_reasons_p-1:0] stage_event_i,
  input  logic                                  instret_i,
  input  logic                                  rd_v_i,
  input  logic [addr_width_lp-1:0]              rd_addr_i,
  output logic                                  rd_v_o,
  output logic [cnt_width_p-1:0]                rd_data_o,
  output logic                                  snapshot_v_o
);

  localparam int idx_width_lp = $clog2(num_reasons_p);
  localparam int num_banks_lp = num_reasons_p + 2;
  localparam int win_width_lp = $clog2(window_cycles_p);

  localparam logic [addr_width_lp-1:0] instret_idx_lp = addr_width_lp'(instret_addr(num_reasons_p));
  localparam logic [addr_width_lp-1:0] cycles_idx_lp  = addr_width_lp'(cycles_addr(num_reasons_p));
  localparam logic [addr_width_lp:0]   num_banks_cmp_lp = (addr_width_lp+1)'(num_banks_lp);
  localparam logic [win_width_lp-1:0]  win_last_lp    = win_width_lp'(window_cycles_p - 1);

  typedef logic [cnt_width_p-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

  logic [idx_width_lp-1:0] reason;
  logic                    reason_v;

  bp_stall_attrib_pipe #(
    .num_stages_p  (num_stages_p),
    .num_reasons_p (num_reasons_p)
  ) attrib_pipe (
    .clk_i         (clk_i),
    .reset_li      (reset_li),
    .flush_i       (freeze_i | clear_i),
    .stage_event_i (stage_event_i),
    .reason_o      (reason),
    .reason_v_o    (reason_v)
  );

  // Banks are indexed by read address: reasons, then instret, then cycles.
  logic [num_banks_lp-1:0][cnt_width_p-1:0] live_q, live_d;
  logic [num_banks_lp-1:0][cnt_width_p-1:0] shadow_q, shadow_d;
  logic [win_width_lp-1:0]                  win_q, win_d;
  logic                                     mode_q, snapshot_q, snapshot_d;
  logic                                     rd_v_q, rd_v_d;
  cnt_t                                     rd_data_q, rd_data_d;

  logic                     counted, mode_change;
  logic [addr_width_lp-1:0] inc_idx;

  assign counted     = en_i & ~freeze_i & ~clear_i;
  assign mode_change = mode_i ^ mode_q;

  always_comb begin
    if (instret_i)     inc_idx = instret_idx_lp;
    else if (reason_v) inc_idx = addr_width_lp'(reason);
    else               inc_idx = addr_width_lp'(e_stall_unknown);
  end

  always_comb begin
    live_d     = live_q;
    shadow_d   = shadow_q;
    win_d      = win_q;
    snapshot_d = 1'b0;

    if (clear_i) begin
      live_d = '0;
      win_d  = '0;
    end else begin
      if (counted) begin
        live_d[cycles_idx_lp] = sat_inc(live_q[cycles_idx_lp]);
        live_d[inc_idx]       = sat_inc(live_q[inc_idx]);
      end
      if (mode_change) begin
        win_d = '0;
      end else if (counted && mode_i) begin
        if (win_q == win_last_lp) begin
          // Shadow captures this cycle's increment before live restarts.
          shadow_d   = live_d;
          live_d     = '0;
          win_d      = '0;
          snapshot_d = 1'b1;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_v_d    = rd_v_i;
    rd_data_d = '0;
    if (rd_v_i && ({1'b0, rd_addr_i} < num_banks_cmp_lp)) begin
      rd_data_d = mode_i ? shadow_q[rd_addr_i] : live_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      live_q     <= '0;
      shadow_q   <= '0;
      win_q      <= '0;
      mode_q     <= 1'b0;
      snapshot_q <= 1'b0;
      rd_v_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      live_q     <= live_d;
      shadow_q   <= shadow_d;
      win_q      <= win_d;
      mode_q     <= mode_i;
      snapshot_q <= snapshot_d;
      rd_v_q     <= rd_v_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_v_o       = rd_v_q;
  assign rd_data_o    = rd_data_q;
  assign snapshot_v_o = snapshot_q;

endmodule

// File: tb/tb_bp_nonsynth_stall_histogram.sv
// Directed scoreboard bench for the stall histogram: reads push expected data,
// a monitor pops and compares whenever rd_v_o is presented.
module tb_bp_nonsynth_stall_histogram;

  localparam int S   = 8;
  localparam int R   = 24;
  localparam int W   = 5;
  localparam int WIN = 16;
  localparam int AW  = $clog2(R + 2);

  logic            clk_i     = 1'b0;
  logic            reset_li  = 1'b0;
  logic            freeze_i  = 1'b0;
  logic            en_i      = 1'b0;
  logic            clear_i   = 1'b0;
  logic            mode_i    = 1'b0;
  logic            instret_i = 1'b0;
  logic            rd_v_i    = 1'b0;
  logic [S*R-1:0]  stage_event_i = '0;
  logic [AW-1:0]   rd_addr_i = '0;
  logic            rd_v_o;
  logic [W-1:0]    rd_data_o;
  logic            snapshot_v_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_snap  = 0;

  typedef struct {
    string      tag;
    logic [W-1:0] value;
  } exp_t;

  exp_t exp_q[$];

  bp_nonsynth_stall_histogram #(
    .num_stages_p    (S),
    .num_reasons_p   (R),
    .cnt_width_p     (W),
    .window_cycles_p (WIN)
  ) dut (
    .clk_i         (clk_i),
    .reset_li      (reset_li),
    .freeze_i      (freeze_i),
    .en_i          (en_i),
    .clear_i       (clear_i),
    .mode_i        (mode_i),
    .stage_event_i (stage_event_i),
    .instret_i     (instret_i),
    .rd_v_i        (rd_v_i),
    .rd_addr_i     (rd_addr_i),
    .rd_v_o        (rd_v_o),
    .rd_data_o     (rd_data_o),
    .snapshot_v_o  (snapshot_v_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic rd(input string name, input int addr, input int data);
    exp_t e;
    e.tag   = name;
    e.value = W'(data);
    exp_q.push_back(e);
    rd_v_i    = 1'b1;
    rd_addr_i = AW'(addr);
    step();
    rd_v_i    = 1'b0;
  endtask

  function automatic logic [S*R-1:0] ev(input int s, input int r);
    logic [S*R-1:0] v;
    v = '0;
    v[s*R + r] = 1'b1;
    return v;
  endfunction

  // Monitor: counts snapshot pulses and scores every presented read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (snapshot_v_o === 1'b1) n_snap++;
      if (rd_v_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rd_v_o with no pending read", rd_v_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check(e.tag, rd_data_o, e.value);
        end
      end
    end
  end

  initial begin
    // Reset state.
    step(2);
    check("reset rd_v_o", rd_v_o, 0);
    check("reset rd_data_o", rd_data_o, 0);
    check("reset snapshot_v_o", snapshot_v_o, 0);
    reset_li = 1'b1;
    step();

    // Count a little, then assert reset asynchronously between edges.
    en_i = 1'b1;
    step(6);
    en_i = 1'b0;
    rd("pre-reset cycles", R + 1, 6);
    #3 reset_li = 1'b0;
    #1;
    check("async reset rd_v_o", rd_v_o, 0);
    check("async reset rd_data_o", rd_data_o, 0);
    check("async reset snapshot_v_o", snapshot_v_o, 0);
    step(2);
    reset_li = 1'b1;
    step();
    for (int a = 0; a < R + 2; a++) rd($sformatf("post-reset addr %0d", a), a, 0);

    // Latency: reason 7 injected at stage 3 reaches the tail 5 cycles later.
    stage_event_i = ev(3, 7);
    en_i = 1'b1;
    step();
    stage_event_i = '0;
    step(4);
    rd("latency reason7 on hit edge", 7, 0);
    rd("latency reason7 after hit", 7, 1);
    step(3);
    en_i = 1'b0;
    rd("latency reason7", 7, 1);
    rd("latency reason0", 0, 9);
    rd("latency cycles", R + 1, 10);

    // Priority, instret override, tail bit 0 ignored, top reason.
    clear_i = 1'b1; step(); clear_i = 1'b0;
    stage_event_i = ev(7, 5) | ev(7, 12); step();
    stage_event_i = '0; en_i = 1'b1; step(); en_i = 1'b0;
    stage_event_i = ev(7, 5) | ev(7, 12); step();
    stage_event_i = '0; en_i = 1'b1; instret_i = 1'b1; step();
    en_i = 1'b0; instret_i = 1'b0;
    stage_event_i = ev(7, 0); step();
    stage_event_i = '0; en_i = 1'b1; step(); en_i = 1'b0;
    stage_event_i = ev(7, 1) | ev(7, 23); step();
    stage_event_i = '0; en_i = 1'b1; step(); en_i = 1'b0;
    rd("priority reason12", 12, 1);
    rd("priority reason5", 5, 0);
    rd("priority instret", R, 1);
    rd("priority reason0", 0, 1);
    rd("priority reason23", 23, 1);
    rd("priority reason1", 1, 0);
    rd("priority cycles", R + 1, 4);

    // Window: 16 counted cycles, first 10 retiring.
    clear_i = 1'b1; mode_i = 1'b1; step(); clear_i = 1'b0;
    en_i = 1'b1; instret_i = 1'b1; step(10);
    instret_i = 1'b0; step(6);
    en_i = 1'b0;
    rd("window shadow instret", R, 10);
    rd("window shadow cycles", R + 1, 16);
    rd("window shadow reason0", 0, 6);
    rd("window shadow reason12", 12, 0);
    mode_i = 1'b0;
    rd("window live instret", R, 0);
    rd("window live cycles", R + 1, 0);
    rd("window live reason0", 0, 0);
    check("window snapshot pulses", n_snap, 1);

    // Saturation: 40 stall cycles on reason 2 with 5-bit counters.
    clear_i = 1'b1; step(); clear_i = 1'b0;
    stage_event_i = ev(7, 2); step();
    en_i = 1'b1; step(40); en_i = 1'b0;
    rd("sat reason2", 2, 31);
    rd("sat cycles", R + 1, 31);
    rd("sat reason0", 0, 0);

    // Freeze: no counting and the pipe is flushed.
    clear_i = 1'b1; step(); clear_i = 1'b0;
    en_i = 1'b1; step(3);
    freeze_i = 1'b1; step(5); freeze_i = 1'b0;
    stage_event_i = '0;
    step();
    en_i = 1'b0;
    rd("freeze cycles", R + 1, 4);
    rd("freeze reason2", 2, 2);
    rd("freeze reason0", 0, 2);

    // Clear collides with the window-closing cycle.
    clear_i = 1'b1; mode_i = 1'b1; step(); clear_i = 1'b0;
    en_i = 1'b1; step(WIN - 1);
    clear_i = 1'b1; step(); clear_i = 1'b0; en_i = 1'b0;
    step(2);
    check("collision no snapshot", n_snap, 1);
    rd("collision shadow instret", R, 10);
    rd("collision shadow cycles", R + 1, 16);
    rd("collision shadow reason0", 0, 6);
    rd("out-of-range shadow", 30, 0);
    mode_i = 1'b0;
    rd("collision live cycles", R + 1, 0);
    rd("collision live instret", R, 0);
    rd("collision live reason0", 0, 0);
    rd("out-of-range live", 30, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("all reads answered", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
